// File: rtl/manual_key_ctl.sv
// PDP-8/I front-panel key sequencer: conditions console keys, requests manual timing, emits MFTP-driven strobes.
// Define KEY_DEBOUNCE_EN to include the per-key debounce stage; otherwise synchronized levels are used directly.
module manual_key_ctl #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17,
    parameter int WAIT_MAX        = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic key_start,
    input  logic key_load_add,
    input  logic key_dep,
    input  logic key_exam,
    input  logic key_cont,
    input  logic key_stop,
    input  logic run,
    input  logic mftp0,
    input  logic mftp1,
    input  logic mftp2,
    output logic mfts_req,
    output logic ld_pc_sr,
    output logic ld_ma_pc,
    output logic mem_rd,
    output logic mem_wr,
    output logic mb_sr,
    output logic pc_inc,
    output logic clr_acl,
    output logic set_run,
    output logic stop_req,
    output logic busy,
    output logic fault
);

    localparam int NK = 6;
    localparam int WW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_T1, S_T2, S_RELEASE} state_t;
    typedef enum logic [2:0] {F_NONE, F_START, F_LOAD, F_DEP, F_EXAM, F_CONT} func_t;

    logic [NK-1:0] key_raw, sync1, sync2, db_lvl;
    logic [4:0]    db_q, press;
    logic [2:0]    mftp, mftp_q, mftp_edge;
    state_t        state, state_next;
    func_t         func, sel_func;
    logic [WW-1:0] wait_cnt;
    logic          expected_edge, timeout_hit;
    logic [7:0]    strobe_d, strobe_q;

    // Key index: 0 START, 1 LOAD ADD, 2 DEP, 3 EXAM, 4 CONT, 5 STOP
    assign key_raw = {key_stop, key_cont, key_exam, key_dep, key_load_add, key_start};
    assign mftp    = {mftp2, mftp1, mftp0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    logic [CNT_W-1:0] db_cnt [NK];

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_lvl <= '0;
            for (int i = 0; i < NK; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NK; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign db_lvl = sync2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q   <= '0;
            mftp_q <= '0;
        end else begin
            db_q   <= db_lvl[4:0];
            mftp_q <= mftp;
        end
    end

    assign press     = db_lvl[4:0] & ~db_q;
    assign mftp_edge = mftp & ~mftp_q;
    assign stop_req  = db_lvl[5];

    always_comb begin
        sel_func = F_NONE;
        if      (press[0]) sel_func = F_START;
        else if (press[1]) sel_func = F_LOAD;
        else if (press[2]) sel_func = F_DEP;
        else if (press[3]) sel_func = F_EXAM;
        else if (press[4]) sel_func = F_CONT;
    end

    // An expected edge beats a timeout landing in the same cycle
    always_comb begin
        expected_edge = 1'b0;
        case (state)
            S_ARM:   expected_edge = mftp_edge[0];
            S_T1:    expected_edge = mftp_edge[1];
            S_T2:    expected_edge = mftp_edge[2];
            default: expected_edge = 1'b0;
        endcase
        timeout_hit = (state == S_ARM || state == S_T1 || state == S_T2)
                      && !expected_edge && (wait_cnt == WW'(WAIT_MAX - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (!run && sel_func != F_NONE) state_next = S_ARM;
            S_ARM:     if (expected_edge) state_next = S_T1; else if (timeout_hit) state_next = S_RELEASE;
            S_T1:      if (expected_edge) state_next = S_T2; else if (timeout_hit) state_next = S_RELEASE;
            S_T2:      if (expected_edge || timeout_hit) state_next = S_RELEASE;
            S_RELEASE: if (db_lvl[4:0] == '0) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // strobe_d bits: ld_pc_sr, ld_ma_pc, mem_rd, mem_wr, mb_sr, pc_inc, clr_acl, set_run
    always_comb begin
        mfts_req = (state == S_ARM) || (state == S_T1) || (state == S_T2);
        busy     = (state != S_IDLE);
        strobe_d = 8'h00;
        if (expected_edge) begin
            case (state)
                S_ARM: if (func == F_EXAM || func == F_DEP) strobe_d = 8'h40;
                S_T1: begin
                    case (func)
                        F_LOAD:  strobe_d = 8'h80;
                        F_EXAM:  strobe_d = 8'h20;
                        F_DEP:   strobe_d = 8'h18;
                        F_START: strobe_d = 8'h02;
                        default: strobe_d = 8'h00;
                    endcase
                end
                S_T2: begin
                    if (func == F_EXAM || func == F_DEP)         strobe_d = 8'h04;
                    else if (func == F_START || func == F_CONT) strobe_d = 8'h01;
                end
                default: strobe_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            func     <= F_NONE;
            fault    <= 1'b0;
            wait_cnt <= '0;
            strobe_q <= '0;
        end else begin
            strobe_q <= strobe_d;
            if (state == S_IDLE && state_next == S_ARM) begin
                func  <= sel_func;
                fault <= 1'b0;
            end
            if (timeout_hit) fault <= 1'b1;
            if (state != state_next)   wait_cnt <= '0;
            else if (mfts_req)         wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign {ld_pc_sr, ld_ma_pc, mem_rd, mem_wr, mb_sr, pc_inc, clr_acl, set_run} = strobe_q;

endmodule
